capture_integrator: RTL

- Receiving end of the capture control interface.
- Consumes cap_ena, cap_start, cap_region and cap_region_size from the capture controller, plus the ADC sample stream.
- Integrates ADC samples over each region window and emits one result per region (region id, signed sum, sample count) through a FWFT FIFO with valid/ready handshake toward readout.

---
 rtl/capture_integrator.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/capture_integrator.sv
//------------------------------------------------------------------------------
// Module      : capture_integrator
// Description : Integrates ADC samples over capture region windows and queues
//               one {region, sum, count, trunc} result per window in a FWFT
//               FIFO. Optional squared-sum accumulator: CAPINT_SUMSQ_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module capture_integrator #(
    parameter int DATA_W     = 18,
    parameter int ACC_W      = 40,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_ena,
    input  logic                 cap_start,
    input  logic [3:0]           cap_region,
    input  logic [15:0]          cap_region_size,
    input  logic                 adc_valid,
    input  logic [DATA_W-1:0]    adc_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_region,
    output logic [ACC_W-1:0]     out_sum,
    output logic [15:0]          out_count,
    output logic                 out_trunc,
`ifdef CAPINT_SUMSQ_EN
    output logic [2*DATA_W+15:0] out_sumsq,
`endif
    output logic                 busy,
    output logic [15:0]          ovf_cnt,
    output logic                 ena_err
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_INTEG = 1'b1;
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_BASE_W = 1 + 16 + ACC_W + 4;
`ifdef CAPINT_SUMSQ_EN
    localparam int c_SQ_W    = 2*DATA_W + 16;
    localparam int c_ENTRY_W = c_BASE_W + c_SQ_W;
`else
    localparam int c_ENTRY_W = c_BASE_W;
`endif
    localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(FIFO_DEPTH);

    logic [0:0]       r_state, w_state_nxt;
    logic [3:0]       r_region;
    logic [15:0]      r_size, r_win_cnt, r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ena_err;
    logic [15:0]      r_ovf_cnt;

    logic             w_start, w_new_zero, w_load, w_accum;
    logic             w_old_push, w_old_trunc, w_zero_push, w_ena_fall;
    logic [15:0]      w_idx, w_cnt_sum;
    logic [ACC_W-1:0] w_sample, w_acc_sum;
    logic [c_BASE_W-1:0]  w_old_base, w_zero_base;
    logic [c_ENTRY_W-1:0] w_old_entry, w_zero_entry;

    assign w_start    = cap_start && cap_ena;
    assign w_new_zero = (cap_region_size == 16'd0);
    assign w_idx      = r_win_cnt + 16'd1;
    assign w_sample   = adc_valid ? {{(ACC_W-DATA_W){adc_data[DATA_W-1]}}, adc_data} : '0;
    assign w_acc_sum  = r_acc + w_sample;
    assign w_cnt_sum  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + {15'd0, adc_valid};

    // A truncated result excludes the cap_start sample; it opens the next window.
    assign w_old_base  = w_old_trunc ? {1'b1, r_cnt, r_acc, r_region}
                                     : {1'b0, w_cnt_sum, w_acc_sum, r_region};
    assign w_zero_base = {1'b0, {15'd0, adc_valid}, w_sample, cap_region};

`ifdef CAPINT_SUMSQ_EN
    logic [c_SQ_W-1:0]     r_sq, w_sq, w_sq_sum;
    logic [2*DATA_W-1:0]   w_adc_x, w_prod;
    assign w_adc_x      = {{DATA_W{adc_data[DATA_W-1]}}, adc_data};
    assign w_prod       = w_adc_x * w_adc_x;
    assign w_sq         = adc_valid ? {16'd0, w_prod} : '0;
    assign w_sq_sum     = r_sq + w_sq;
    assign w_old_entry  = {(w_old_trunc ? r_sq : w_sq_sum), w_old_base};
    assign w_zero_entry = {w_sq, w_zero_base};
`else
    assign w_old_entry  = w_old_base;
    assign w_zero_entry = w_zero_base;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accum     = 1'b0;
        w_old_push  = 1'b0;
        w_old_trunc = 1'b0;
        w_zero_push = 1'b0;
        w_ena_fall  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    if (w_new_zero) begin
                        w_zero_push = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = c_INTEG;
                    end
                end
            end
            c_INTEG: begin
                if (!cap_ena) begin
                    w_ena_fall  = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    if (w_idx == r_size) begin
                        w_old_push  = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else if (cap_start) begin
                        w_old_push  = 1'b1;
                        w_old_trunc = 1'b1;
                    end else begin
                        w_accum = 1'b1;
                    end
                    // A zero-size restart completes on this clock as a second push.
                    if (cap_start) begin
                        if (w_new_zero) begin
                            w_zero_push = 1'b1;
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_load      = 1'b1;
                            w_state_nxt = c_INTEG;
                        end
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_region  <= 4'd0;
            r_size    <= 16'd0;
            r_win_cnt <= 16'd0;
            r_cnt     <= 16'd0;
            r_acc     <= '0;
            r_ena_err <= 1'b0;
`ifdef CAPINT_SUMSQ_EN
            r_sq      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_region  <= cap_region;
                r_size    <= cap_region_size;
                r_win_cnt <= 16'd0;
                r_acc     <= w_sample;
                r_cnt     <= {15'd0, adc_valid};
`ifdef CAPINT_SUMSQ_EN
                r_sq      <= w_sq;
`endif
            end else if (w_accum) begin
                r_win_cnt <= w_idx;
                r_acc     <= w_acc_sum;
                r_cnt     <= w_cnt_sum;
`ifdef CAPINT_SUMSQ_EN
                r_sq      <= w_sq_sum;
`endif
            end
            if (w_ena_fall) begin
                r_ena_err <= 1'b1;
            end
        end
    end

    // Result FIFO: up to two writes per clock, slot 0 always filled first.
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]        r_fill, w_free;
    logic [c_ENTRY_W-1:0] w_slot0, w_head;
    logic                 w_req0, w_req1, w_acc0, w_acc1, w_pop, w_empty;
    logic [1:0]           w_n_req, w_n_acc, w_drops;
    logic [16:0]          w_ovf_sum;

    assign w_req0    = w_old_push || w_zero_push;
    assign w_req1    = w_old_push && w_zero_push;
    assign w_slot0   = w_old_push ? w_old_entry : w_zero_entry;
    assign w_empty   = (r_fill == '0);
    assign w_pop     = !w_empty && out_ready;
    assign w_free    = c_DEPTH - r_fill + (c_AW+1)'(w_pop);
    assign w_acc0    = w_req0 && (w_free != '0);
    assign w_acc1    = w_req1 && (w_free >= (c_AW+1)'(2));
    assign w_n_req   = {1'b0, w_req0} + {1'b0, w_req1};
    assign w_n_acc   = {1'b0, w_acc0} + {1'b0, w_acc1};
    assign w_drops   = w_n_req - w_n_acc;
    assign w_ovf_sum = {1'b0, r_ovf_cnt} + {15'd0, w_drops};

    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_mem[r_wr_ptr] <= w_slot0;
        end
        if (w_acc1) begin
            r_mem[r_wr_ptr + c_AW'(1)] <= w_zero_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_ovf_cnt <= 16'd0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + c_AW'(w_n_acc);
            r_rd_ptr  <= r_rd_ptr + c_AW'(w_pop);
            r_fill    <= r_fill + (c_AW+1)'(w_n_acc) - (c_AW+1)'(w_pop);
            r_ovf_cnt <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
        end
    end

    // Fields read as zero whenever nothing is presented.
    assign w_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_valid  = !w_empty;
    assign out_region = w_head[3:0];
    assign out_sum    = w_head[ACC_W+3:4];
    assign out_count  = w_head[ACC_W+19:ACC_W+4];
    assign out_trunc  = w_head[ACC_W+20];
`ifdef CAPINT_SUMSQ_EN
    assign out_sumsq  = w_head[c_ENTRY_W-1:c_BASE_W];
`endif
    assign busy       = (r_state == c_INTEG);
    assign ovf_cnt    = r_ovf_cnt;
    assign ena_err    = r_ena_err;

endmodule

`default_nettype wire
